hazard_ctrl: RTL and testbench

Pipeline hazard controller driving the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers of the 5-stage RV32I core. Detects load-use hazards and taken branches/jumps resolved in EX. Freezes the whole pipeline while the data memory is not ready, with a timeout error. Keeps saturating performance counters for stalls, flushes and memory-wait cycles.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } mem_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter on the falling edge, used for the hazard performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generation for the 5-stage core: load-use, control flush, and
// whole-pipeline freeze on data-memory wait with a sticky timeout error.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_addrD,
  input  logic [4:0]        rs2_addrD,
  input  logic [4:0]        rdE,
  input  logic              MemReadE,
  input  logic              PCSrcE,
  input  logic              mem_reqM,
  input  logic              mem_readyM,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushW,
  output logic              mem_err,
  output logic [PERF_W-1:0] lu_cnt,
  output logic [PERF_W-1:0] fl_cnt,
  output logic [PERF_W-1:0] mw_cnt
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic load_use, mem_busy, freeze;
  logic lu_issue, fl_issue, mw_issue;

  assign load_use = MemReadE && (rdE != REG_X0) && ((rdE == rs1_addrD) || (rdE == rs2_addrD));
  assign mem_busy = mem_reqM && !mem_readyM;
  assign freeze   = mem_busy || (state_q == ERR);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_busy) begin
          state_d    = WAIT;
          wait_cnt_d = CntW'(1);
        end
      end
      WAIT: begin
        if (mem_readyM || !mem_reqM) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CntW'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Freeze beats control flush, which beats load-use (the dependent ID instruction is discarded).
  always_comb begin
    stallF   = 1'b0;
    stallD   = 1'b0;
    stallE   = 1'b0;
    stallM   = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    flushW   = 1'b0;
    lu_issue = 1'b0;
    fl_issue = 1'b0;
    mw_issue = 1'b0;
    if (!rst) begin
      if (freeze) begin
        stallF   = 1'b1;
        stallD   = 1'b1;
        stallE   = 1'b1;
        stallM   = 1'b1;
        flushW   = 1'b1;
        mw_issue = 1'b1;
      end else if (PCSrcE) begin
        flushD   = 1'b1;
        flushE   = 1'b1;
        fl_issue = 1'b1;
      end else if (load_use) begin
        stallF   = 1'b1;
        stallD   = 1'b1;
        flushE   = 1'b1;
        lu_issue = 1'b1;
      end
    end
  end

  assign mem_err = (state_q == ERR);

  sat_counter #(.W(PERF_W)) u_lu_cnt (.clk(clk), .rst(rst), .inc(lu_issue), .count(lu_cnt));
  sat_counter #(.W(PERF_W)) u_fl_cnt (.clk(clk), .rst(rst), .inc(fl_issue), .count(fl_cnt));
  sat_counter #(.W(PERF_W)) u_mw_cnt (.clk(clk), .rst(rst), .inc(mw_issue), .count(mw_cnt));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations per cycle,
// the monitor pops and compares them mid-cycle on the rising edge.
module tb_hazard_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned PerfW      = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       rs1_addrD = '0, rs2_addrD = '0, rdE = '0;
  logic             MemReadE = 1'b0, PCSrcE = 1'b0, mem_reqM = 1'b0, mem_readyM = 1'b0;
  logic             stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
  logic [PerfW-1:0] lu_cnt, fl_cnt, mw_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .PERF_W(PerfW)) dut (
    .clk(clk), .rst(rst), .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD), .rdE(rdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .mem_reqM(mem_reqM), .mem_readyM(mem_readyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .mem_err(mem_err),
    .lu_cnt(lu_cnt), .fl_cnt(fl_cnt), .mw_cnt(mw_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] stall;  // {F,D,E,M}
    logic [2:0] flush;  // {D,E,W}
    logic       err;
    int         lu, fl, mw;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string nm, string field, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, req);
    end
  endfunction

  always @(posedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, "stall", int'({stallF, stallD, stallE, stallM}), int'(e.stall));
      check(e.name, "flush", int'({flushD, flushE, flushW}), int'(e.flush));
      check(e.name, "mem_err", int'(mem_err), int'(e.err));
      check(e.name, "lu_cnt", int'(lu_cnt), e.lu);
      check(e.name, "fl_cnt", int'(fl_cnt), e.fl);
      check(e.name, "mw_cnt", int'(mw_cnt), e.mw);
    end
  end

  // Inputs change just after the falling (active) edge; expectations hold at the next rising edge.
  task automatic cyc(input string nm, input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic mrd, input logic pc, input logic req,
                     input logic rdy, input logic [3:0] st, input logic [2:0] fl, input logic err,
                     input int lu, input int flc, input int mw);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; rs1_addrD = rs1; rs2_addrD = rs2; rdE = rd;
    MemReadE = mrd; PCSrcE = pc; mem_reqM = req; mem_readyM = rdy;
    e.name = nm; e.stall = st; e.flush = fl; e.err = err;
    e.lu = lu; e.fl = flc; e.mw = mw;
    q.push_back(e);
  endtask

  initial begin
    int budget;
    // name           rst rs1 rs2 rdE mrd pc req rdy  stall    flush   err lu fl mw
    cyc("reset",      1,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  0, 0, 0);
    cyc("idle",       0,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  0, 0, 0);
    cyc("lu_hit",     0,  1,  5,  5,  1,  0, 0,  0,  4'b1100, 3'b010, 0,  0, 0, 0);
    cyc("lu_clear",   0,  1,  5,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  1, 0, 0);
    cyc("lu_x0",      0,  0,  0,  0,  1,  0, 0,  0,  4'b0000, 3'b000, 0,  1, 0, 0);
    cyc("br",         0,  0,  0,  0,  0,  1, 0,  0,  4'b0000, 3'b110, 0,  1, 0, 0);
    cyc("br_lu",      0,  7,  2,  7,  1,  1, 0,  0,  4'b0000, 3'b110, 0,  1, 1, 0);
    cyc("br_after",   0,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  1, 2, 0);
    cyc("mw1",        0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  1, 2, 0);
    cyc("mw2",        0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  1, 2, 1);
    cyc("mw3",        0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  1, 2, 2);
    cyc("mw_ready",   0,  0,  0,  0,  0,  0, 1,  1,  4'b0000, 3'b000, 0,  1, 2, 3);
    cyc("mw_idle",    0,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  1, 2, 3);
    cyc("prio_all",   0,  9,  0,  9,  1,  1, 1,  0,  4'b1111, 3'b001, 0,  1, 2, 3);
    cyc("prio_rel",   0,  9,  0,  9,  1,  1, 0,  0,  4'b0000, 3'b110, 0,  1, 2, 4);
    cyc("prio_idle",  0,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  1, 3, 4);
    // Timeout after MEM_TIMEOUT+1 busy cycles, then ERR ignores ready and rst clears it.
    cyc("to_reset",   1,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  0, 0, 0);
    cyc("to_b1",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 0);
    cyc("to_b2",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 1);
    cyc("to_b3",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 2);
    cyc("to_b4",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 3);
    cyc("to_b5",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 4);
    cyc("err_rdy",    0,  0,  0,  0,  0,  0, 1,  1,  4'b1111, 3'b001, 1,  0, 0, 5);
    cyc("err_br",     0,  0,  0,  0,  0,  1, 0,  0,  4'b1111, 3'b001, 1,  0, 0, 6);
    cyc("err_sat",    0,  0,  0,  0,  0,  0, 0,  0,  4'b1111, 3'b001, 1,  0, 0, 7);
    cyc("err_sat2",   0,  0,  0,  0,  0,  0, 0,  0,  4'b1111, 3'b001, 1,  0, 0, 7);
    cyc("err_rst",    1,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  0, 0, 0);
    cyc("err_clear",  0,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc("lu_sat",   0,  3,  0,  3,  1,  0, 0,  0,  4'b1100, 3'b010, 0,  (i > 7) ? 7 : i, 0, 0);
    end
    cyc("lu_sat_end", 0,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  7, 0, 0);
    // Reset in mid-WAIT: wait_cnt must restart, so ERR takes a full five busy cycles again.
    cyc("rw_b1",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  7, 0, 0);
    cyc("rw_b2",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  7, 0, 1);
    cyc("rw_rst",     1,  0,  0,  0,  0,  0, 1,  0,  4'b0000, 3'b000, 0,  0, 0, 0);
    cyc("rw_idle",    0,  0,  0,  0,  0,  0, 0,  0,  4'b0000, 3'b000, 0,  0, 0, 0);
    cyc("rw_c1",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 0);
    cyc("rw_c2",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 1);
    cyc("rw_c3",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 2);
    cyc("rw_c4",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 3);
    cyc("rw_c5",      0,  0,  0,  0,  0,  0, 1,  0,  4'b1111, 3'b001, 0,  0, 0, 4);
    cyc("rw_err",     0,  0,  0,  0,  0,  0, 0,  0,  4'b1111, 3'b001, 1,  0, 0, 5);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
